// File: rtl/decoder_seq_pkg.sv
// Shared types for the sequenced one-hot decoder: load modes and FSM states.
package decoder_seq_pkg;

  // Load mode, sampled together with in_sel on an accepted load.
  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'b00,
    MODE_SCAN_UP = 2'b01,
    MODE_SCAN_DN = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  // Controller state. Encodings are fixed so older tooling that probes
  // the state register keeps reading the same values.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIRECT = 2'b01,
    ST_SCAN   = 2'b10,
    ST_HOLD   = 2'b11
  } state_e;

endpackage

// File: rtl/decoder_seq_n_onehot_dec.sv
// Combinational binary-to-one-hot decoder, also used by the legacy 4-to-16 path.
module onehot_dec #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] out
);

  // Set exactly the bit addressed by sel.
  always_comb begin
    // NOTE: out gets a full default first so no path leaves it unassigned (no latch).
    out      = '0;
    out[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq_n.sv
// Registered one-hot decoder with output enable, valid/ready load and
// autonomous up/down scanning with a programmable dwell per position.
module decoder_seq_n
  import decoder_seq_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [1:0]            mode,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] out,
  output logic                  out_valid,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;

  state_e               state, state_n;
  mode_e                mode_reg, mode_n;
  logic [SEL_W-1:0]     sel, sel_n;
  logic [DWELL_W-1:0]   dwell_reg, dwell_reg_n;
  logic [DWELL_W-1:0]   dwell_cnt, dwell_cnt_n;
  logic                 out_valid_n;
  logic                 wrap_n;
  logic                 boundary;
  logic                 load;
  logic                 scan_dn;
  logic [OUT_W-1:0]     dec;

  // Last dwell cycle of the current scan position; equality compare means
  // the counter never runs past dwell_reg.
  assign boundary = (dwell_cnt == dwell_reg);

  // Ready is a pure function of registered state: always open outside a
  // scan, and only on a position boundary while scanning.
  assign in_ready = (state != ST_SCAN) || boundary;
  assign load     = in_valid && in_ready;
  assign scan_dn  = (mode_reg == MODE_SCAN_DN);

  // Next-state logic: a load wins over a scan step, and only a step can wrap.
  always_comb begin
    state_n     = state;
    mode_n      = mode_reg;
    sel_n       = sel;
    dwell_reg_n = dwell_reg;
    dwell_cnt_n = dwell_cnt;
    out_valid_n = out_valid;
    wrap_n      = 1'b0;

    if (load) begin
      sel_n       = in_sel;
      dwell_cnt_n = '0;
      out_valid_n = 1'b1;
      unique case (mode_e'(mode))
        MODE_DIRECT: begin
          state_n     = ST_DIRECT;
          mode_n      = MODE_DIRECT;
          dwell_reg_n = dwell;
        end
        MODE_SCAN_UP, MODE_SCAN_DN: begin
          state_n     = ST_SCAN;
          mode_n      = mode_e'(mode);
          dwell_reg_n = dwell;
        end
        MODE_HOLD: begin
          // Freeze at in_sel; keep the stored direction and dwell.
          state_n = ST_HOLD;
        end
      endcase
    end else if (state == ST_SCAN) begin
      if (boundary) begin
        dwell_cnt_n = '0;
        if (scan_dn) begin
          sel_n  = sel - 1'b1;
          wrap_n = (sel == '0);
        end else begin
          sel_n  = sel + 1'b1;
          wrap_n = (sel == '1);
        end
      end else begin
        dwell_cnt_n = dwell_cnt + 1'b1;
      end
    end
  end

  // Decode the next select so out lines up with the sel/wrap update.
  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel (sel_n),
    .out (dec)
  );

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_reg  <= MODE_DIRECT;
      sel       <= '0;
      dwell_reg <= '0;
      dwell_cnt <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      out       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_n;
      mode_reg  <= mode_n;
      sel       <= sel_n;
      dwell_reg <= dwell_reg_n;
      dwell_cnt <= dwell_cnt_n;
      out_valid <= out_valid_n;
      wrap      <= wrap_n;
      out       <= (en && out_valid_n) ? dec : '0;
    end
  end

endmodule

// File: tb/tb_decoder_seq_n.sv
// Randomised and directed self-checking bench for decoder_seq_n against a
// time-based behavioural model (position derived from cycles since load).
module tb_decoder_seq_n;

  localparam int SEL_W   = 4;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel = '0;
  logic [1:0]         mode = 2'b00;
  logic [DWELL_W-1:0] dwell = '0;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Model: a scan is "base + dir * floor(t / (dwell+1))" modulo 16.
  bit m_valid, m_scan, m_wrap;
  int m_base, m_dir, m_dwell, m_t;
  bit last_load;

  decoder_seq_n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .mode      (mode),
    .dwell     (dwell),
    .out       (out),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int model_pos();
    int p;
    if (!m_scan) return m_base;
    p = m_base + m_dir * (m_t / (m_dwell + 1));
    return ((p % OUT_W) + OUT_W) % OUT_W;
  endfunction

  function automatic bit model_ready();
    return !m_scan || ((m_t % (m_dwell + 1)) == m_dwell);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_scan = 0; m_wrap = 0;
    m_base = 0; m_dir = 1; m_dwell = 0; m_t = 0;
  endtask

  // One clock: check ready, advance the model with the applied inputs,
  // then compare the registered outputs 1 time unit after the edge.
  task automatic cycle();
    bit rdy, ld, en_s;
    int sel_s, mode_s, dwell_s, p;
    logic [OUT_W-1:0] exp_out;
    rdy     = model_ready();
    check("in_ready", in_ready, rdy);
    ld      = in_valid && rdy;
    en_s    = en;
    sel_s   = in_sel;
    mode_s  = mode;
    dwell_s = dwell;
    @(posedge clk);
    m_wrap = 0;
    if (ld) begin
      m_valid = 1;
      m_t     = 0;
      m_base  = sel_s;
      case (mode_s)
        0: begin m_scan = 0; m_dwell = dwell_s; end
        1: begin m_scan = 1; m_dir = 1;  m_dwell = dwell_s; end
        2: begin m_scan = 1; m_dir = -1; m_dwell = dwell_s; end
        default: m_scan = 0;
      endcase
    end else if (m_scan) begin
      m_t++;
      if ((m_t % (m_dwell + 1)) == 0) begin
        p = model_pos();
        m_wrap = (m_dir == 1) ? (p == 0) : (p == OUT_W - 1);
      end
    end
    p       = model_pos();
    exp_out = (en_s && m_valid) ? (OUT_W'(1) << p) : '0;
    #1;
    check("out", out, exp_out);
    check("out_valid", out_valid, m_valid);
    check("wrap", wrap, m_wrap);
    check("onehot_max", ($countones(out) <= 1), 1);
    last_load = ld;
  endtask

  // Hold a load request until it is accepted, with a cycle budget.
  task automatic load(input int s, input int md, input int dw);
    int n;
    in_sel   = SEL_W'(s);
    mode     = 2'(md);
    dwell    = DWELL_W'(dw);
    in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_load && n < 600);
    if (!last_load) check("load_timeout", n, 0);
    in_valid = 1'b0;
  endtask

  // Assert reset between edges, check outputs before the next edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_wrap", wrap, 0);
    check("rst_in_ready", in_ready, 1);
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();
    last_load = 0;

    // Power-on reset.
    repeat (2) @(posedge clk);
    #3;
    check("por_out", out, 0);
    check("por_out_valid", out_valid, 0);
    check("por_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: DIRECT load, output enable gating.
    load(5, 0, 0);
    check("t1_out", out, 16'h0020);
    check("t1_out_valid", out_valid, 1);
    repeat (5) cycle();
    check("t1_hold", out, 16'h0020);
    en = 1'b0; cycle();
    check("t1_en0", out, 16'h0000);
    en = 1'b1; cycle();
    check("t1_en1", out, 16'h0020);

    // 2: SCAN_UP with dwell 2 across the top wrap.
    load(14, 1, 2);
    check("t2_first", out, 16'h4000);
    for (int i = 1; i <= 6; i++) begin
      cycle();
      check("t2_seq", out, (i < 3) ? 16'h4000 : (i < 6) ? 16'h8000 : 16'h0001);
      check("t2_wrap", wrap, (i == 6));
    end
    cycle();
    check("t2_wrap_once", wrap, 0);

    // 3: SCAN_DN with dwell 0, stepping every cycle.
    load(0, 2, 0);
    check("t3_a", out, 16'h0001);
    cycle(); check("t3_b", out, 16'h8000); check("t3_b_wrap", wrap, 1);
    cycle(); check("t3_c", out, 16'h4000); check("t3_c_wrap", wrap, 0);

    // 4: dwell 3, in_valid held high, HOLD load lands on the boundary.
    load(0, 1, 3);
    in_sel = 4'd9; mode = 2'b11; in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_load && n < 20);
    in_valid = 1'b0;
    check("t4_ready_cycle", n, 4);
    check("t4_out", out, 16'h0200);
    check("t4_wrap", wrap, 0);
    repeat (10) cycle();
    check("t4_frozen", out, 16'h0200);

    // 5: asynchronous reset mid-scan, nothing until the next load.
    load(3, 1, 1);
    repeat (5) cycle();
    async_reset();
    repeat (4) cycle();
    check("t5_idle_out", out, 0);
    check("t5_idle_valid", out_valid, 0);

    // 6: back-to-back DIRECT sweep.
    in_valid = 1'b1; mode = 2'b00;
    for (int s = 0; s < OUT_W; s++) begin
      in_sel = SEL_W'(s);
      cycle();
      check("t6_out", out, OUT_W'(1) << s);
      check("t6_popcount", $countones(out), 1);
    end
    in_valid = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 3) == 0);
      in_sel   = SEL_W'($urandom);
      mode     = 2'($urandom);
      dwell    = ($urandom_range(0, 15) == 0) ? DWELL_W'($urandom_range(0, 20))
                                               : DWELL_W'($urandom_range(0, 4));
      cycle();
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decoder_seq_n.md
Name: decoder_seq_n

Overview:
Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder. It is the successor to the fixed combinational 4-to-16 decoder. It adds:
- an output enable;
- a valid/ready load handshake;
- an autonomous scan mode that steps the active output up or down, with a programmable dwell per position.

It drives row/column strobes, LED scanning and bank selects.

Parameters:
SEL_W, 4, select width; OUT_W = 2**SEL_W (localparam, not overridable)
DWELL_W, 8, width of the dwell counter and the dwell input

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  output enable; 0 forces out to all zeros, state is kept
in_valid  input  1  load request
in_ready  output  1  block accepts a load this cycle
in_sel  input  SEL_W  index to load
mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DN, 11 HOLD; sampled with a load
dwell  input  DWELL_W  cycles per scan position minus 1; sampled with a load
out  output  OUT_W  one-hot output, registered
out_valid  output  1  out holds a decoded value
wrap  output  1  one-cycle pulse when a scan wraps

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - out = 0, out_valid = 0, wrap = 0, in_ready = 1;
  - internal sel = 0, dwell_cnt = 0;
  - FSM = IDLE.
- Handshake:
  - A load occurs on a clock edge where in_valid && in_ready.
  - in_ready = 1 in IDLE, DIRECT and HOLD.
  - In SCAN, in_ready = 1 only in the final dwell cycle of a position (dwell_cnt == dwell_reg), so a reload lands on a position boundary.
  - in_ready depends only on state; it has no combinational path from in_valid.
- Load effects, all registered with 1-cycle latency:
  - sel <= in_sel, mode_reg <= mode, dwell_reg <= dwell, dwell_cnt <= 0, out_valid <= 1.
  - Next state from mode: 00 -> DIRECT, 01/10 -> SCAN (direction stored), 11 -> HOLD.
  - HOLD loads sel but keeps the stored direction and dwell, so it freezes a scan at a chosen index.
- out (registered every cycle):
  - out = en && out_valid ? (1 << sel) : 0.
  - Exactly one bit set when enabled and valid; never more than one.
  - out updates the cycle after a load or a step.
- FSM states: IDLE, DIRECT, SCAN, HOLD.
  - IDLE -> per mode on load.
  - DIRECT / HOLD: sel is static; any load re-enters per mode.
  - SCAN:
    - dwell_cnt increments each cycle.
    - When dwell_cnt == dwell_reg: dwell_cnt <= 0 and sel steps ±1 modulo OUT_W.
    - dwell = 0 means a step every cycle.
- wrap:
  - Pulses 1 for one cycle, aligned with the out update, when sel steps from OUT_W-1 to 0 (up) or from 0 to OUT_W-1 (down).
  - It never pulses in DIRECT or HOLD, or on a load.
- Simultaneous events:
  - A load on a scan boundary takes priority over the step; no wrap pulse.
  - en = 0 does not stop scanning. Stepping and wrap continue; only out is gated.
- Width rules: sel wraps naturally at SEL_W bits. dwell_cnt is DWELL_W wide and is compared with equality, so it never overflows.
- Reset mid-scan: everything returns to reset values immediately, asynchronously, without waiting for a clock.

Decomposition:
- Package decoder_seq_pkg:
  - mode_e enum (DIRECT, SCAN_UP, SCAN_DN, HOLD);
  - state_e enum (IDLE, DIRECT, SCAN, HOLD).
- One sub-module, onehot_dec (purely combinational, parametrised by SEL_W). It holds the 1 << sel function and is reused by the legacy 4-to-16 path.
- The FSM, dwell counter and handshake stay in the top.

Test Plan (SEL_W=4, DWELL_W=8):
1. Reset, then load in_sel=5, mode=00, en=1 -> out=16'h0020, out_valid=1, one cycle after the load; holds indefinitely. Then en=0 -> out=16'h0000; en=1 -> 16'h0020 again.
2. Load in_sel=14, mode=01, dwell=2 -> out=0x4000 for 3 cycles, then 0x8000 for 3 cycles, then 0x0001 with wrap=1 for exactly one cycle.
3. Load in_sel=0, mode=10, dwell=0 -> out steps 0x0001, 0x8000 (wrap=1), 0x4000, changing every cycle.
4. During SCAN with dwell=3:
   - in_valid held high -> in_ready=1 only in the final dwell cycle;
   - load in_sel=9, mode=11 on the boundary -> out=0x0200 frozen, no wrap, no further stepping.
5. Assert rst asynchronously between clock edges mid-scan -> out=0, out_valid=0, wrap=0, in_ready=1 before the next edge. After release, no output until a new load.
6. Exhaustive DIRECT sweep: in_sel 0..15 back-to-back -> each out equals 1<<in_sel, popcount(out)==1 on every cycle.
